// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer that drives a shared single-cycle ALU.
// Optional ALU_MULDIV_EARLY_EXIT_EN ends MUL once the remaining multiplier bits are zero.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic            busy_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [2:0]      alu_op_o,
    input  logic [XLEN-1:0] alu_result_i
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_SUB  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    logic [2:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;

    logic [XLEN-1:0] rem_shift;
    logic            take_sub;
    logic            mul_last;

    assign rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    // The shifted-out MSB means the true partial remainder already exceeds the divisor.
    assign take_sub  = rem_q[XLEN-1] || (alu_result_i == '0);

`ifdef ALU_MULDIV_EARLY_EXIT_EN
    assign mul_last = (cnt_q == LAST) || ((mplier_q >> 1) == '0);
`else
    assign mul_last = (cnt_q == LAST);
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = ALU_ADD;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d  = req_op_i;
                    cnt_d = '0;
                    acc_d = '0;
                    rem_d = '0;
                    case (req_op_i)
                        OP_MUL: begin
                            mcand_d  = req_a_i;
                            mplier_d = req_b_i;
                            state_d  = S_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            if (req_b_i != '0) begin
                                quo_d   = req_a_i;
                                dvs_d   = req_b_i;
                                state_d = S_CMP;
                            end else begin
                                quo_d   = '1;
                                rem_d   = req_a_i;
                                pend_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            pend_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                alu_a_o  = acc_q;
                alu_b_o  = mcand_q;
                alu_op_o = ALU_ADD;
                if (mplier_q[0]) acc_d = alu_result_i;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_last) state_d = S_DONE;
            end
            S_CMP: begin
                alu_a_o  = rem_shift;
                alu_b_o  = dvs_q;
                alu_op_o = ALU_SLTU;
                rem_d    = rem_shift;
                quo_d    = {quo_q[XLEN-2:0], 1'b0};
                if (take_sub) begin
                    state_d = S_SUB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_DONE;
                end
            end
            S_SUB: begin
                alu_a_o  = rem_q;
                alu_b_o  = dvs_q;
                alu_op_o = ALU_SUB;
                rem_d    = alu_result_i;
                quo_d[0] = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == LAST) ? S_DONE : S_CMP;
            end
            S_DONE: begin
                // Divide-by-zero and reserved ops spend one silent cycle here first.
                if (pend_q) pend_d = 1'b0;
                else if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_DONE) && !pend_q;

    always_comb begin
        case (op_q)
            OP_DIVU: resp_result_o = quo_q;
            OP_REMU: resp_result_o = rem_q;
            default: resp_result_o = acc_q;
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed corner cases plus random ops
// against an arithmetic reference model, with a behavioural ALU beside the DUT.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_result_o(resp_result),
        .busy_o       (busy),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result)
    );

    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b101: alu_result = {31'b0, (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b00: begin p = 64'(a) * 64'(b); return p[31:0]; end
            2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b11: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        int hi;
        if (op == 2'b01 || (op[1] && b == 0)) return 1;
        if (op == 2'b00) begin
`ifdef ALU_MULDIV_EARLY_EXIT_EN
            hi = 0;
            for (int i = 0; i < 32; i++) if (b[i]) hi = i;
            return hi + 1;
`else
            hi = 32;
            return hi;
`endif
        end
        return 32 + $countones(a / b);
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        logic        op_seen_bad;
        exp_res     = ref_result(op, a, b);
        exp_lat     = ref_latency(op, a, b);
        op_seen_bad = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = 1'b0;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 300) begin
            if (op == 2'b00 && alu_op !== 3'b000) op_seen_bad = 1'b1;
            @(negedge clk);
            req_valid = $urandom_range(0, 1) == 1;
            req_op    = 2'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".result"}, 64'(resp_result), 64'(exp_res));
        if (op == 2'b00) chk({tag, ".alu_op"}, 64'(op_seen_bad), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {30'b0, resp_valid, req_ready, resp_result}, {30'b0, 2'b10, exp_res});
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".to_idle"}, {61'b0, resp_valid, req_ready, busy}, {61'b0, 3'b010});
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic        leak;
        #1;
        chk("reset.outputs", {resp_result, 27'b0, req_ready, resp_valid, busy, alu_op[1:0]},
            {32'h0, 27'b0, 5'b10000});
        chk("reset.alu", {alu_a, alu_b}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6",  2'b00, 32'd7, 32'd6, 0);
        run_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        run_op("remu_ovf",  2'b11, 32'h8000_0000, 32'd3, 0);
        run_op("divu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("divu_by0",  2'b10, 32'd5, 32'd0, 0);
        run_op("remu_by0",  2'b11, 32'd5, 32'd0, 0);
        run_op("reserved",  2'b01, 32'd9, 32'd9, 0);
        run_op("mul_b0",    2'b00, 32'h1234_5678, 32'd0, 0);
        run_op("hold10",    2'b10, 32'd1000, 32'd33, 10);

        for (int k = 0; k < 16; k++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op("random", rop, ra, rb, $urandom_range(0, 2));
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'd1;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid.outputs", {resp_result, 27'b0, req_ready, resp_valid, busy, alu_op[1:0]},
            {32'h0, 27'b0, 5'b10000});
        chk("rst_mid.alu", {29'b0, alu_op, alu_a}, 64'h0);
        @(negedge clk);
        rst  = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || busy !== 1'b0) leak = 1'b1;
        end
        chk("rst_mid.no_resp", 64'(leak), 64'd0);
        run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 0);
        chk("mul_3x3.const", 64'(ref_result(2'b00, 32'd3, 32'd3)), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
